// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_DATA_W = 16;
  localparam int unsigned ARB_ADDR_W = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StClear
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle: fetch port (P0) and load/store port (P1).
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = ARB_DATA_W,
  parameter int unsigned ADDR_W = ARB_ADDR_W
);

  logic              P0_Req;
  logic              P0_We;
  logic [ADDR_W-1:0] P0_Addr;
  logic [DATA_W-1:0] P0_Wdata;
  logic              P0_Ack;
  logic [DATA_W-1:0] P0_Rdata;
  logic              P0_Err;

  logic              P1_Req;
  logic              P1_We;
  logic [ADDR_W-1:0] P1_Addr;
  logic [DATA_W-1:0] P1_Wdata;
  logic              P1_Ack;
  logic [DATA_W-1:0] P1_Rdata;
  logic              P1_Err;

  modport master (
    output P0_Req, P0_We, P0_Addr, P0_Wdata,
    output P1_Req, P1_We, P1_Addr, P1_Wdata,
    input  P0_Ack, P0_Rdata, P0_Err,
    input  P1_Ack, P1_Rdata, P1_Err
  );

  modport slave (
    input  P0_Req, P0_We, P0_Addr, P0_Wdata,
    input  P1_Req, P1_We, P1_Addr, P1_Wdata,
    output P0_Ack, P0_Rdata, P0_Err,
    output P1_Ack, P1_Rdata, P1_Err
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; a masked port is never granted.
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic       grant_valid,
  output logic       grant_id
);

  logic [1:0] eligible;
  logic       last_q;

  assign eligible    = req & ~mask;
  assign grant_valid = |eligible;

  // On a tie, favour the port that was not granted last.
  always_comb begin
    grant_id = PORT0;
    if (&eligible) begin
      grant_id = (last_q == PORT1) ? PORT0 : PORT1;
    end else if (eligible[1]) begin
      grant_id = PORT1;
    end
  end

  // Last-grant pointer; starts at P1 so P0 wins the first tie.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_q <= PORT1;
    end else if (grant_valid) begin
      last_q <= grant_id;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-write/single-read data memory between two requesters and
// provides a sequencer that zeroes every implemented word.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = ARB_DATA_W,
  parameter int unsigned ADDR_W       = ARB_ADDR_W,
  parameter int unsigned DEPTH        = 1024,
  parameter bit          CLEAR_ON_RST = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset,
  mem_arbiter_if.slave      cpu,
  input  logic              Clear_Start,
  output logic              Clear_Busy,
  output logic              Clear_Done,
  output logic              Mem_Write_Enable,
  output logic [ADDR_W-1:0] Mem_Write_Address,
  output logic [DATA_W-1:0] Mem_Write_Data,
  output logic [ADDR_W-1:0] Mem_Read_Address,
  input  logic [DATA_W-1:0] Mem_Read_Data
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  arb_state_e        state_q, state_d;
  logic              lat_port_q, lat_port_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              done_q, done_d;
  logic              first_q;

  logic              clear_go;
  logic              lat_in_range;
  logic [1:0]        req;
  logic [1:0]        mask;
  logic              grant_valid;
  logic              grant_id;
  logic [DATA_W-1:0] rd_value;

  assign clear_go     = Clear_Start || (CLEAR_ON_RST && first_q);
  assign lat_in_range = 32'(lat_addr_q) < DEPTH;
  assign req          = {cpu.P1_Req, cpu.P0_Req};
  // Only IDLE may grant, and a clear request takes priority over any access.
  assign mask         = (state_q == StIdle && !clear_go) ? ack_q : 2'b11;
  assign rd_value     = lat_in_range ? Mem_Read_Data : '0;

  rr_arbiter_2 u_rr (
    .Clock       (Clock),
    .Reset       (Reset),
    .req         (req),
    .mask        (mask),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next-state, transaction latch, response and memory-side strobes.
  always_comb begin
    state_d           = state_q;
    lat_port_d        = lat_port_q;
    lat_we_d          = lat_we_q;
    lat_addr_d        = lat_addr_q;
    lat_wdata_d       = lat_wdata_q;
    cnt_d             = cnt_q;
    ack_d             = 2'b00;
    err_d             = 2'b00;
    rdata0_d          = rdata0_q;
    rdata1_d          = rdata1_q;
    done_d            = 1'b0;
    Mem_Write_Enable  = 1'b0;
    Mem_Write_Address = '0;
    Mem_Write_Data    = '0;
    Mem_Read_Address  = '0;
    unique case (state_q)
      StIdle: begin
        if (clear_go) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (grant_valid) begin
          state_d     = StAccess;
          lat_port_d  = grant_id;
          lat_we_d    = (grant_id == PORT0) ? cpu.P0_We    : cpu.P1_We;
          lat_addr_d  = (grant_id == PORT0) ? cpu.P0_Addr  : cpu.P1_Addr;
          lat_wdata_d = (grant_id == PORT0) ? cpu.P0_Wdata : cpu.P1_Wdata;
        end
      end
      StAccess: begin
        Mem_Read_Address = lat_addr_q;
        if (lat_we_q && lat_in_range) begin
          Mem_Write_Enable  = 1'b1;
          Mem_Write_Address = lat_addr_q;
          Mem_Write_Data    = lat_wdata_q;
        end
        ack_d[lat_port_q] = 1'b1;
        err_d[lat_port_q] = !lat_in_range;
        if (lat_port_q == PORT0) begin
          rdata0_d = rd_value;
        end else begin
          rdata1_d = rd_value;
        end
        state_d = StIdle;
      end
      StClear: begin
        Mem_Write_Enable  = 1'b1;
        Mem_Write_Address = ADDR_W'(cnt_q);
        cnt_d             = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DEPTH - 1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered responses; reset abandons any access or clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      lat_port_q  <= PORT0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      cnt_q       <= '0;
      ack_q       <= 2'b00;
      err_q       <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      done_q      <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      lat_port_q  <= lat_port_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      done_q      <= done_d;
      first_q     <= 1'b0;
    end
  end

  assign cpu.P0_Ack   = ack_q[0];
  assign cpu.P1_Ack   = ack_q[1];
  assign cpu.P0_Err   = err_q[0];
  assign cpu.P1_Err   = err_q[1];
  assign cpu.P0_Rdata = rdata0_q;
  assign cpu.P1_Rdata = rdata1_q;
  assign Clear_Busy   = (state_q == StClear);
  assign Clear_Done   = done_q;

endmodule
